// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the CPU instruction memory.
// Receives LEN_LO, LEN_HI, 4*N little-endian payload bytes and an XOR
// checksum, writes each assembled word through the memory write port and
// holds the CPU in reset until a complete, checksum-correct image is loaded.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid   byte present on in_data
//   in_data    stream byte
//   in_ready   loader accepts in_data this cycle
//   wren       instruction-memory write enable (one-cycle pulse)
//   wraddress  instruction-memory word address (holds between writes)
//   data       instruction word (holds between writes)
//   cpu_reset  active-high CPU reset, held while loading or after an error
//   busy       load in progress
//   done       last load succeeded
//   err        last load failed
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [31:0]       data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state;
  logic [7:0]        len_lo;
  logic [15:0]       remain;     // words still to be written
  logic [ADDR_W-1:0] addr;       // index of the next word to write
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;      // first three bytes of the current word
  logic [7:0]        chk;
  logic              accept;
  logic [15:0]       len_word;
  logic              len_bad;

  // Pure state decode: in_ready never depends on in_valid.
  assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHECK);
  assign in_ready = busy;
  assign accept   = in_valid && in_ready;

  assign len_word = {in_data, len_lo};
  assign len_bad  = (len_word == 16'd0) || (32'(len_word) > DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      len_lo    <= '0;
      remain    <= '0;
      addr      <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      chk       <= '0;
      wren      <= 1'b0;
      wraddress <= '0;
      data      <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN_LO;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
            addr      <= '0;
            chk       <= '0;
            byte_cnt  <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (len_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              remain <= len_word;
              state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            chk      <= chk ^ in_data;
            shreg    <= {in_data, shreg[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wren      <= 1'b1;
              wraddress <= addr;
              data      <= {in_data, shreg};
              addr      <= addr + 1'b1;
              remain    <= remain - 16'd1;
              if (remain == 16'd1) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (chk == in_data) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. A vector table of
// whole loads is applied in a loop; expected memory writes are queued when
// the matching payload byte is driven and checked when wren is observed.
// Hand-written sequences cover a stalled stream with an ignored start and
// an asynchronous reset in the middle of a load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wren;
  logic [7:0]  wraddress;
  logic [31:0] data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wren(wren),
    .wraddress(wraddress), .data(data), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] word;
  } wr_t;

  typedef struct {
    int unsigned n;
    logic [31:0] seed;
    logic [31:0] step;
    bit          bad_chk;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_writes;
    logic [7:0]  exp_last;
  } vec_t;

  wr_t         exp_q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned writes_seen = 0;
  logic [7:0]  last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every observed write must match the oldest queued one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wren === 1'b1) begin
      writes_seen++;
      last_addr = wraddress;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", wraddress, data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {24'd0, wraddress}, {24'd0, e.addr});
        check("write_data", data, e.word);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned n = 0;
    bit acc = 1'b0;
    if (stall) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: got in_ready=0 for 50 cycles expected acceptance of %h", b);
    end
  endtask

  task automatic run_load(input vec_t v, input bit stall, input bit mid_start);
    logic [7:0]  x = '0;
    logic [7:0]  b;
    logic [31:0] w;
    logic [31:0] nn;
    int unsigned ws0 = writes_seen;
    bit legal = (v.n >= 1 && v.n <= 256);
    nn = v.n;
    pulse_start();
    check("cpu_reset_after_start", {31'd0, cpu_reset}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("err_cleared", {31'd0, err}, 32'd0);
    send_byte(nn[7:0], stall);
    send_byte(nn[15:8], stall);
    if (legal) begin
      for (int unsigned k = 0; k < v.n; k++) begin
        w = v.seed + k * v.step;
        for (int unsigned j = 0; j < 4; j++) begin
          b = w[8*j +: 8];
          x = x ^ b;
          if (mid_start && k == 0 && j == 2) begin
            pulse_start();
            check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
          end
          if (j == 3) exp_q.push_back({k[7:0], w});
          send_byte(b, stall);
        end
      end
      send_byte(v.bad_chk ? ~x : x, stall);
    end
    check("done", {31'd0, done}, {31'd0, v.exp_done});
    check("err", {31'd0, err}, {31'd0, v.exp_err});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("in_ready_end", {31'd0, in_ready}, 32'd0);
    check("cpu_reset_end", {31'd0, cpu_reset}, {31'd0, !v.exp_done});
    check("write_count", writes_seen - ws0, v.exp_writes);
    check("queue_drained", exp_q.size(), 32'd0);
    if (v.exp_writes > 0) check("last_addr", {24'd0, last_addr}, {24'd0, v.exp_last});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wren"}, {31'd0, wren}, 32'd0);
    check({tag, "_wraddress"}, {24'd0, wraddress}, 32'd0);
    check({tag, "_data"}, data, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  vec_t tbl[6];
  vec_t stall_vec;

  initial begin
    //         n    seed          step          bad   done  err   writes last
    tbl[0] = '{2,   32'h12345678, 32'hCC796877, 1'b0, 1'b1, 1'b0, 2,     8'h01};
    tbl[1] = '{2,   32'h12345678, 32'hCC796877, 1'b1, 1'b0, 1'b1, 2,     8'h01};
    tbl[2] = '{0,   32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0,     8'h00};
    tbl[3] = '{257, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0,     8'h00};
    tbl[4] = '{3,   32'h0BADF00D, 32'h11111111, 1'b0, 1'b1, 1'b0, 3,     8'h02};
    tbl[5] = '{256, 32'h0,        32'h01010101, 1'b0, 1'b1, 1'b0, 256,   8'hFF};
    stall_vec = '{1, 32'hA5C3_5A3C, 32'h0, 1'b0, 1'b1, 1'b0, 1, 8'h00};

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("idle");

    for (int i = 0; i < 6; i++) run_load(tbl[i], 1'b0, 1'b0);

    // N = 1 with random in_valid gaps and a start pulse inside DATA.
    run_load(stall_vec, 1'b1, 1'b1);

    // Reset after six payload bytes; word 0 has been written by then.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({8'h00, 32'h12345678});
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    check("pre_reset_data", data, 32'h12345678);
    check("pre_reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midload");
    check("queue_after_reset", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_load(tbl[0], 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
